// File: rtl/motion_seq.sv
// motion_seq: queues move commands, derives accel/decel step counts by sequential division,
// and loads one pwm axis per move, waiting for axis_done before starting the next.
module motion_seq #(
  parameter int W = 28,
  parameter int QDEPTH = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  str_frq,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_frq,
  input  logic [W-1:0]  cmd_dc,
  input  logic [W-1:0]  cmd_acc,
  input  logic [W-1:0]  cmd_dec,
  input  logic [W-1:0]  cmd_cnt,
  input  logic          abort,
  output logic          axis_load,
  output logic          axis_abort,
  output logic [W-1:0]  axis_frq,
  output logic [W-1:0]  axis_dc,
  output logic [W-1:0]  axis_acc,
  output logic [W-1:0]  axis_dec,
  output logic [W-1:0]  axis_cnt,
  output logic [W-1:0]  axis_acc_cnt,
  output logic [W-1:0]  axis_dec_cnt,
  input  logic          axis_done,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] moves_done
);
  localparam int AW = $clog2(QDEPTH);
  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] LAST = BW'(W - 1);
  typedef enum logic [2:0] {IDLE, DIV_A, DIV_D, CLAMP, LOAD, RUN} state_t;
  state_t state;
  logic [5*W-1:0] mem [QDEPTH];
  logic [5*W-1:0] head;
  logic [AW:0] wp, rp;
  logic full, empty, push, pop;
  logic [W-1:0] frq, dc, acc, dec, cnt, diff, quo, acc_s, h_frq, h_acc, h_dec, h_cnt, dvsr, quo_nx;
  logic [W:0] rem, rem_sh, rem_nx, sum;
  logic [BW-1:0] bcnt;
  logic ge, tri_prof;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign cmd_ready = rst_n & !full & !abort;
  assign push = cmd_valid & cmd_ready;
  assign pop = (state == IDLE) & !empty & !abort;
  assign busy = (state != IDLE) || !empty;
  assign head = mem[rp[AW-1:0]];
  assign h_frq = head[0+:W];
  assign h_acc = head[2*W+:W];
  assign h_dec = head[3*W+:W];
  assign h_cnt = head[4*W+:W];
  // one restoring-division step; quo doubles as the dividend shift register
  always_comb begin
    dvsr = state == DIV_A ? acc : dec;
    rem_sh = {rem[W-1:0], quo[W-1]};
    ge = rem_sh >= {1'b0, dvsr};
    rem_nx = ge ? rem_sh - {1'b0, dvsr} : rem_sh;
    quo_nx = {quo[W-2:0], ge};
    sum = {1'b0, acc_s} + {1'b0, quo};
    tri_prof = sum > {1'b0, cnt};
  end
  always_ff @(posedge clk) if (push) mem[wp[AW-1:0]] <= {cmd_cnt, cmd_dec, cmd_acc, cmd_dc, cmd_frq};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      {frq, dc, acc, dec, cnt, diff, quo, acc_s, rem, bcnt} <= '0;
      {axis_frq, axis_dc, axis_acc, axis_dec, axis_cnt, axis_acc_cnt, axis_dec_cnt} <= '0;
      axis_load <= 1'b0;
      axis_abort <= 1'b0;
      err <= 1'b0;
      moves_done <= '0;
    end else begin
      axis_load <= 1'b0;
      axis_abort <= 1'b0;
      if (abort) begin
        wp <= '0;
        rp <= '0;
        state <= IDLE;
        axis_abort <= (state == LOAD) || (state == RUN);
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        case (state)
          IDLE: if (!empty) begin
            {cnt, dec, acc, dc, frq} <= head;
            if (h_acc == '0 || h_dec == '0) begin
              err <= 1'b1;
              moves_done <= moves_done + 1'b1;
            end else if (h_cnt == '0) begin
              moves_done <= moves_done + 1'b1;
            end else begin
              diff <= h_frq >= str_frq ? '0 : str_frq - h_frq;
              quo <= h_frq >= str_frq ? '0 : str_frq - h_frq;
              rem <= '0;
              bcnt <= '0;
              state <= DIV_A;
            end
          end
          DIV_A: begin
            rem <= rem_nx;
            quo <= quo_nx;
            bcnt <= bcnt + 1'b1;
            if (bcnt == LAST) begin
              acc_s <= quo_nx;
              quo <= diff;
              rem <= '0;
              bcnt <= '0;
              state <= DIV_D;
            end
          end
          DIV_D: begin
            rem <= rem_nx;
            quo <= quo_nx;
            bcnt <= bcnt + 1'b1;
            if (bcnt == LAST) state <= CLAMP;
          end
          CLAMP: begin
            {axis_frq, axis_dc, axis_acc, axis_dec, axis_cnt} <= {frq, dc, acc, dec, cnt};
            axis_acc_cnt <= tri_prof ? cnt >> 1 : acc_s;
            axis_dec_cnt <= tri_prof ? cnt >> 1 : cnt - quo;
            axis_load <= 1'b1;
            state <= LOAD;
          end
          LOAD: state <= RUN;
          RUN: if (axis_done) begin
            moves_done <= moves_done + 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_motion_seq.sv
// tb_motion_seq: scoreboard bench for motion_seq; expected axis loads are queued at command
// push time from a behavioural model and compared when axis_load fires.
module tb_motion_seq;
  localparam int W = 28;
  localparam int CW = 16;
  localparam logic [W-1:0] STR = 100000;
  typedef struct {logic [W-1:0] frq, dc, acc, dec, cnt, ac, dcn;} exp_t;
  logic clk = 0, rst_n = 0, cmd_valid = 0, abort = 0, axis_done = 0;
  logic [W-1:0] str_frq = STR, cmd_frq = 0, cmd_dc = 0, cmd_acc = 0, cmd_dec = 0, cmd_cnt = 0;
  logic cmd_ready, axis_load, axis_abort, busy, err;
  logic [W-1:0] axis_frq, axis_dc, axis_acc, axis_dec, axis_cnt, axis_acc_cnt, axis_dec_cnt;
  logic [CW-1:0] moves_done;
  exp_t q[$];
  exp_t e;
  int n_pass = 0, n_total = 0;
  logic [CW-1:0] exp_moves = 0;

  motion_seq #(.W(W), .QDEPTH(4), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .str_frq(str_frq), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_frq(cmd_frq), .cmd_dc(cmd_dc), .cmd_acc(cmd_acc), .cmd_dec(cmd_dec), .cmd_cnt(cmd_cnt),
    .abort(abort), .axis_load(axis_load), .axis_abort(axis_abort), .axis_frq(axis_frq),
    .axis_dc(axis_dc), .axis_acc(axis_acc), .axis_dec(axis_dec), .axis_cnt(axis_cnt),
    .axis_acc_cnt(axis_acc_cnt), .axis_dec_cnt(axis_dec_cnt), .axis_done(axis_done),
    .busy(busy), .err(err), .moves_done(moves_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input longint f, dcy, a, d, c);
    longint diff, as, ds;
    exp_t r;
    diff = f >= longint'(STR) ? 0 : longint'(STR) - f;
    as = diff / a;
    ds = diff / d;
    r.frq = W'(f); r.dc = W'(dcy); r.acc = W'(a); r.dec = W'(d); r.cnt = W'(c);
    r.ac = (as + ds > c) ? W'(c / 2) : W'(as);
    r.dcn = (as + ds > c) ? W'(c / 2) : W'(c - ds);
    return r;
  endfunction

  task automatic push_cmd(input longint f, dcy, a, d, c, input bit loads, output int waited);
    waited = 0;
    cmd_frq = W'(f); cmd_dc = W'(dcy); cmd_acc = W'(a); cmd_dec = W'(d); cmd_cnt = W'(c);
    cmd_valid = 1;
    while (!cmd_ready && waited < 300) begin
      tick;
      waited++;
    end
    tick;
    cmd_valid = 0;
    if (loads) q.push_back(model(f, dcy, a, d, c));
  endtask

  task automatic wait_load(output int cyc);
    cyc = 0;
    while (!axis_load && cyc < 300) begin
      tick;
      cyc++;
    end
  endtask

  task automatic finish_move;
    tick;
    axis_done = 1;
    tick;
    axis_done = 0;
    exp_moves++;
  endtask

  task automatic test_reset;
    #1;
    n_total++;
    if ({cmd_ready, axis_load, axis_abort, busy, err, moves_done} !== '0) $display("FAIL reset_hold outputs=%b want 0", {cmd_ready, axis_load, axis_abort, busy, err, moves_done});
    else n_pass++;
    tick; tick; tick;
    rst_n = 1;
    #1;
    n_total++;
    if ({cmd_ready, busy, moves_done, axis_frq, axis_acc_cnt, axis_dec_cnt} !== {1'b1, 1'b0, {CW{1'b0}}, {3*W{1'b0}}}) $display("FAIL reset_release ready=%b busy=%b moves=%0d", cmd_ready, busy, moves_done);
    else n_pass++;
  endtask

  task automatic test_trapezoid(input longint c, input string nm);
    int w, cyc;
    push_cmd(1000, 5000, 100, 100, c, 1, w);
    wait_load(cyc);
    e = q.pop_front();
    n_total++;
    if (cyc != 58) $display("FAIL %s_latency got=%0d want=58", nm, cyc);
    else n_pass++;
    n_total++;
    if ({axis_load, axis_frq, axis_dc, axis_acc, axis_dec, axis_cnt, axis_acc_cnt, axis_dec_cnt} !== {1'b1, e.frq, e.dc, e.acc, e.dec, e.cnt, e.ac, e.dcn})
      $display("FAIL %s_fields acc_cnt=%0d dec_cnt=%0d want %0d/%0d", nm, axis_acc_cnt, axis_dec_cnt, e.ac, e.dcn);
    else n_pass++;
    finish_move;
    n_total++;
    if ({axis_load, busy, moves_done} !== {1'b0, 1'b0, exp_moves}) $display("FAIL %s_done load=%b busy=%b moves=%0d want moves=%0d", nm, axis_load, busy, moves_done, exp_moves);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int w, cyc, stalls;
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(1000 + i * 7000, 100 + i, 50 + i * 10, 200 - i * 20, 3000 + i * 4000, 1, w);
      stalls += w;
    end
    n_total++;
    if (stalls != 0) $display("FAIL b2b_accept stall_cycles=%0d want=0", stalls);
    else n_pass++;
    cmd_valid = 1;
    #1;
    n_total++;
    if (cmd_ready !== 1'b0) $display("FAIL b2b_full ready=%b want=0", cmd_ready);
    else n_pass++;
    cmd_valid = 0;
    for (int i = 0; i < 5; i++) begin
      wait_load(cyc);
      e = q.pop_front();
      n_total++;
      if ({axis_load, axis_frq, axis_cnt, axis_acc_cnt, axis_dec_cnt} !== {1'b1, e.frq, e.cnt, e.ac, e.dcn})
        $display("FAIL b2b_load%0d frq=%0d cnt=%0d acc_cnt=%0d dec_cnt=%0d want %0d %0d %0d %0d", i, axis_frq, axis_cnt, axis_acc_cnt, axis_dec_cnt, e.frq, e.cnt, e.ac, e.dcn);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (cyc != 58) $display("FAIL b2b_gap%0d cycles=%0d want=58", i, cyc);
        else n_pass++;
      end
      finish_move;
    end
    n_total++;
    if ({cmd_ready, busy, moves_done} !== {1'b1, 1'b0, exp_moves}) $display("FAIL b2b_end ready=%b busy=%b moves=%0d want %0d", cmd_ready, busy, moves_done, exp_moves);
    else n_pass++;
  endtask

  task automatic test_abort;
    int w, cyc, loads;
    for (int i = 0; i < 3; i++) push_cmd(2000, 10, 100, 100, 8000, 1, w);
    wait_load(cyc);
    e = q.pop_front();
    n_total++;
    if ({axis_load, axis_acc_cnt} !== {1'b1, e.ac}) $display("FAIL abort_first_load load=%b acc_cnt=%0d want %0d", axis_load, axis_acc_cnt, e.ac);
    else n_pass++;
    tick;
    abort = 1;
    cmd_valid = 1;
    #1;
    n_total++;
    if (cmd_ready !== 1'b0) $display("FAIL abort_ready ready=%b want=0", cmd_ready);
    else n_pass++;
    tick;
    abort = 0;
    cmd_valid = 0;
    q.delete();
    n_total++;
    if ({axis_abort, busy} !== 2'b10) $display("FAIL abort_pulse axis_abort=%b busy=%b want 1/0", axis_abort, busy);
    else n_pass++;
    tick;
    n_total++;
    if (axis_abort !== 1'b0) $display("FAIL abort_width axis_abort=%b want=0", axis_abort);
    else n_pass++;
    loads = 0;
    for (int i = 0; i < 100; i++) begin
      if (axis_load) loads++;
      tick;
    end
    n_total++;
    if ({loads, moves_done, busy} !== {32'd0, exp_moves, 1'b0}) $display("FAIL abort_quiet loads=%0d moves=%0d busy=%b want 0/%0d/0", loads, moves_done, busy, exp_moves);
    else n_pass++;
  endtask

  task automatic test_zero_acc;
    int w, cyc;
    push_cmd(1000, 10, 0, 100, 5000, 0, w);
    push_cmd(200000, 20, 100, 100, 4000, 1, w);
    exp_moves++;
    wait_load(cyc);
    e = q.pop_front();
    n_total++;
    if ({err, moves_done} !== {1'b1, exp_moves}) $display("FAIL zero_skip err=%b moves=%0d want 1/%0d", err, moves_done, exp_moves);
    else n_pass++;
    n_total++;
    if ({axis_load, axis_frq, axis_acc_cnt, axis_dec_cnt} !== {1'b1, e.frq, W'(0), W'(4000)}) $display("FAIL zero_next frq=%0d acc_cnt=%0d dec_cnt=%0d want %0d/0/4000", axis_frq, axis_acc_cnt, axis_dec_cnt, e.frq);
    else n_pass++;
    finish_move;
    n_total++;
    if ({err, moves_done} !== {1'b1, exp_moves}) $display("FAIL zero_sticky err=%b moves=%0d want 1/%0d", err, moves_done, exp_moves);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    int w;
    push_cmd(1000, 10, 100, 100, 10000, 0, w);
    repeat (W + W / 2) tick;
    #2;
    rst_n = 0;
    #1;
    n_total++;
    if ({cmd_ready, axis_load, axis_abort, busy, err, moves_done, axis_frq, axis_dc, axis_acc, axis_dec, axis_cnt, axis_acc_cnt, axis_dec_cnt} !== '0)
      $display("FAIL async_reset ready=%b busy=%b err=%b moves=%0d frq=%0d", cmd_ready, busy, err, moves_done, axis_frq);
    else n_pass++;
    tick;
    #2;
    rst_n = 1;
    tick;
    exp_moves = 0;
    n_total++;
    if ({cmd_ready, busy, err, moves_done, axis_abort} !== {1'b1, 1'b0, 1'b0, exp_moves, 1'b0}) $display("FAIL after_reset ready=%b busy=%b err=%b moves=%0d", cmd_ready, busy, err, moves_done);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_trapezoid(10000, "trap");
    test_trapezoid(1000, "tri");
    test_back_to_back;
    test_abort;
    test_zero_acc;
    test_async_reset;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
